// File: rtl/bus_responder_if.sv
// rtl/bus_responder_if.sv - CPU bus and chip-select bundle between the CPU/decoder and the responder
//
// Purpose: groups the CPU bus-cycle handshake, the decoded region selects and
// the bus-error status into one bundle.
// Signals:
//   as_n          CPU address strobe, active low
//   flash_ce      flash select, active low
//   wram_ce       work RAM select, active low
//   eeprom_ce     EEPROM select, active low
//   expansion_ce  expansion select, active low
//   pio_ce        PIO select, active high
//   exp_dtack_n   acknowledge from the expansion header, active low
//   berr_clear    single-cycle pulse clearing berr_flag
//   dtack_n       data-transfer acknowledge to the CPU, active low
//   berr_n        bus error to the CPU, active low
//   busy          a bus cycle is in progress
//   berr_flag     sticky bus-error indication
// Modports: master = CPU/decoder side, slave = responder side.
interface bus_responder_if;
  logic as_n;
  logic flash_ce;
  logic wram_ce;
  logic eeprom_ce;
  logic expansion_ce;
  logic pio_ce;
  logic exp_dtack_n;
  logic berr_clear;
  logic dtack_n;
  logic berr_n;
  logic busy;
  logic berr_flag;

  modport master (
    output as_n, flash_ce, wram_ce, eeprom_ce, expansion_ce, pio_ce,
    output exp_dtack_n, berr_clear,
    input  dtack_n, berr_n, busy, berr_flag
  );

  modport slave (
    input  as_n, flash_ce, wram_ce, eeprom_ce, expansion_ce, pio_ce,
    input  exp_dtack_n, berr_clear,
    output dtack_n, berr_n, busy, berr_flag
  );
endinterface

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - CPU bus-cycle responder generating DTACK#/BERR# per decoded region
//
// Purpose: on an address strobe, latches the decoded region, waits that
// region's wait-state count (or relays the expansion acknowledge) and drives
// dtack_n; raises berr_n when the expansion header or an unmapped access
// fails to acknowledge within TIMEOUT cycles.
// Ports:
//   clk      system clock, CPU bus synchronous to it
//   reset_n  asynchronous active-low reset
//   bus      bus_responder_if.slave: as_n, region selects, exp_dtack_n,
//            berr_clear in; dtack_n, berr_n, busy, berr_flag out
module bus_responder #(
  parameter int FLASH_WS  = 2,
  parameter int WRAM_WS   = 0,
  parameter int EEPROM_WS = 3,
  parameter int PIO_WS    = 1,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 7
) (
  input  logic           clk,
  input  logic           reset_n,
  bus_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    BERR
  } state_t;

  typedef enum logic [2:0] {
    R_NONE,
    R_FLASH,
    R_WRAM,
    R_EEPROM,
    R_PIO,
    R_EXP
  } region_t;

  localparam logic [CNT_W-1:0] FLASH_LOAD   = CNT_W'(FLASH_WS);
  localparam logic [CNT_W-1:0] WRAM_LOAD    = CNT_W'(WRAM_WS);
  localparam logic [CNT_W-1:0] EEPROM_LOAD  = CNT_W'(EEPROM_WS);
  localparam logic [CNT_W-1:0] PIO_LOAD     = CNT_W'(PIO_WS);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  region_t            region_q, region_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dtack_q, dtack_d;
  logic               berr_q, berr_d;
  logic               flag_q, flag_d;
  logic               count_up_region;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      region_q <= R_NONE;
      cnt_q    <= '0;
      dtack_q  <= 1'b1;
      berr_q   <= 1'b1;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      cnt_q    <= cnt_d;
      dtack_q  <= dtack_d;
      berr_q   <= berr_d;
      flag_q   <= flag_d;
    end
  end

  // Expansion and unmapped cycles share the count-up timeout path; internal
  // regions count their wait states down to zero.
  assign count_up_region = (region_q == R_EXP) || (region_q == R_NONE);

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    cnt_d    = cnt_q;
    dtack_d  = dtack_q;
    berr_d   = berr_q;
    // A bus error raised on the same edge overrides the clear below.
    flag_d   = bus.berr_clear ? 1'b0 : flag_q;

    case (state_q)
      IDLE: begin
        if (!bus.as_n) begin
          state_d = WAIT;
          if (!bus.flash_ce) begin
            region_d = R_FLASH;
            cnt_d    = FLASH_LOAD;
          end else if (!bus.wram_ce) begin
            region_d = R_WRAM;
            cnt_d    = WRAM_LOAD;
          end else if (!bus.eeprom_ce) begin
            region_d = R_EEPROM;
            cnt_d    = EEPROM_LOAD;
          end else if (bus.pio_ce) begin
            region_d = R_PIO;
            cnt_d    = PIO_LOAD;
          end else if (!bus.expansion_ce) begin
            region_d = R_EXP;
            cnt_d    = '0;
          end else begin
            region_d = R_NONE;
            cnt_d    = '0;
          end
        end
      end

      WAIT: begin
        // CPU abandoning the cycle wins over any acknowledge or timeout.
        if (bus.as_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (count_up_region) begin
          if ((region_q == R_EXP) && !bus.exp_dtack_n) begin
            dtack_d = 1'b0;
            state_d = ACK;
          end else if (cnt_q == TIMEOUT_LAST) begin
            berr_d  = 1'b0;
            flag_d  = 1'b1;
            state_d = BERR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q == '0) begin
          dtack_d = 1'b0;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ACK, BERR: begin
        if (bus.as_n) begin
          dtack_d = 1'b1;
          berr_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.dtack_n   = dtack_q;
  assign bus.berr_n    = berr_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.berr_flag = flag_q;

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - scoreboard testbench for bus_responder
//
// Purpose: drives directed and randomized CPU bus cycles; expected responses
// come from a timing formula per region and are checked by a monitor.
// Ports: none (top-level bench).
module tb_bus_responder;
  localparam int FLASH_WS  = 2;
  localparam int WRAM_WS   = 0;
  localparam int EEPROM_WS = 3;
  localparam int PIO_WS    = 1;
  localparam int TIMEOUT   = 64;

  logic clk = 1'b0;
  logic reset_n;

  bus_responder_if bus ();

  bus_responder #(
    .FLASH_WS  (FLASH_WS),
    .WRAM_WS   (WRAM_WS),
    .EEPROM_WS (EEPROM_WS),
    .PIO_WS    (PIO_WS),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (7)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the number of the edge just taken.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;  // 1 = dtack_n, 2 = berr_n
    int at;    // edge after which the output is first low
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   exp_flag = 1'b0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever dtack_n or berr_n falls.
  initial begin
    bit   pd;
    bit   pb;
    exp_t e;
    pd = 1'b1;
    pb = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!bus.dtack_n || !bus.berr_n)
          check("dtack_berr_exclusive", int'(bus.dtack_n | bus.berr_n), 1);
        if ((!bus.dtack_n && pd) || (!bus.berr_n && pb)) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_response: got dtack_n=%b berr_n=%b required no response (edge %0d)",
                     bus.dtack_n, bus.berr_n, cyc);
          end else begin
            e = exp_q.pop_front();
            check("resp_kind", bus.dtack_n ? 2 : 1, e.kind);
            check("resp_edge", cyc, e.at);
          end
        end
      end
      pd = bus.dtack_n;
      pb = bus.berr_n;
    end
  end

  // One CPU bus cycle. sf..sx: region selected (logical, not pin level).
  // k: expansion ack offset (0 = never). abort_a: as_n sampled high at
  // E0+abort_a (0 = no abort). hold: extra edges as_n stays low after the
  // response. clr_at: berr_clear sampled at E0+clr_at (0 = none).
  task automatic run_cycle(input bit sf, input bit sw, input bit se, input bit sp,
                           input bit sx, input int k, input int abort_a,
                           input int hold, input int clr_at);
    int   kind;
    int   d;
    int   e0;
    int   end_off;
    int   n;
    int   clr;
    bit   is_exp;
    exp_t it;

    kind   = 1;
    is_exp = !sf && !sw && !se && !sp && sx;
    if (sf)      d = FLASH_WS + 1;
    else if (sw) d = WRAM_WS + 1;
    else if (se) d = EEPROM_WS + 1;
    else if (sp) d = PIO_WS + 1;
    else if (is_exp && k >= 1 && k <= TIMEOUT) d = k;
    else begin
      kind = 2;
      d    = TIMEOUT;
    end
    if (abort_a > 0 && abort_a <= d) kind = 0;
    end_off = (kind == 0) ? abort_a : d + hold + 1;
    clr = (clr_at > end_off) ? 0 : clr_at;
    if (kind == 2)    exp_flag = (clr > d) ? 1'b0 : 1'b1;
    else if (clr > 0) exp_flag = 1'b0;

    bus.as_n         = 1'b0;
    bus.flash_ce     = !sf;
    bus.wram_ce      = !sw;
    bus.eeprom_ce    = !se;
    bus.pio_ce       = sp;
    bus.expansion_ce = !sx;
    bus.exp_dtack_n  = 1'b1;
    bus.berr_clear   = 1'b0;
    e0 = cyc + 1;
    if (kind != 0) begin
      it.kind = kind;
      it.at   = e0 + d;
      exp_q.push_back(it);
    end
    @(negedge clk);
    check("busy_in_cycle", int'(bus.busy), 1);

    while (cyc < e0 + end_off) begin
      n = cyc + 1 - e0;
      bus.as_n         = (n >= end_off);
      bus.flash_ce     = 1'($urandom_range(0, 1));
      bus.wram_ce      = 1'($urandom_range(0, 1));
      bus.eeprom_ce    = 1'($urandom_range(0, 1));
      bus.pio_ce       = 1'($urandom_range(0, 1));
      bus.expansion_ce = 1'($urandom_range(0, 1));
      if (is_exp) bus.exp_dtack_n = !(k >= 1 && n >= k);
      else        bus.exp_dtack_n = 1'($urandom_range(0, 1));
      bus.berr_clear = (clr > 0 && n == clr);
      @(negedge clk);
      if (kind != 0 && cyc - e0 >= d && cyc - e0 < end_off)
        check("resp_held", int'(kind == 1 ? bus.dtack_n : bus.berr_n), 0);
    end

    bus.berr_clear = 1'b0;
    check("release_dtack_n", int'(bus.dtack_n), 1);
    check("release_berr_n", int'(bus.berr_n), 1);
    check("release_busy", int'(bus.busy), 0);
    check("berr_flag", int'(bus.berr_flag), int'(exp_flag));
  endtask

  task automatic pulse_clear();
    bus.berr_clear = 1'b1;
    @(negedge clk);
    bus.berr_clear = 1'b0;
    exp_flag = 1'b0;
    check("flag_cleared", int'(bus.berr_flag), 0);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1);
  end

  initial begin
    int   e0;
    int   r;
    int   k;
    int   a;
    int   h;
    int   c;
    exp_t it;

    reset_n          = 1'b0;
    bus.as_n         = 1'b1;
    bus.flash_ce     = 1'b1;
    bus.wram_ce      = 1'b1;
    bus.eeprom_ce    = 1'b1;
    bus.expansion_ce = 1'b1;
    bus.pio_ce       = 1'b0;
    bus.exp_dtack_n  = 1'b1;
    bus.berr_clear   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_dtack_n", int'(bus.dtack_n), 1);
    check("reset_berr_n", int'(bus.berr_n), 1);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_berr_flag", int'(bus.berr_flag), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);

    // Directed: each region, expansion relay and timeout, unmapped, flag.
    run_cycle(0, 1, 0, 0, 0, 0, 0, 5, 0);        // WRAM, held 5 cycles
    run_cycle(1, 0, 0, 0, 0, 0, 0, 2, 0);        // flash
    run_cycle(0, 0, 1, 0, 0, 0, 0, 1, 0);        // EEPROM
    run_cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);        // PIO
    run_cycle(0, 0, 0, 0, 1, 7, 0, 2, 0);        // expansion ack at E0+7
    run_cycle(0, 0, 0, 0, 1, 0, 0, 1, 0);        // expansion timeout
    pulse_clear();
    run_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);        // unmapped timeout
    pulse_clear();
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, TIMEOUT);  // clear coincident with error
    run_cycle(1, 0, 0, 0, 0, 0, 2, 0, 0);        // flash aborted at E0+2
    run_cycle(1, 1, 0, 0, 0, 0, 0, 1, 0);        // flash beats wram
    run_cycle(0, 0, 0, 0, 1, TIMEOUT, 0, 0, 0);  // ack on the timeout edge
    run_cycle(0, 0, 0, 1, 1, 1, 0, 0, 0);        // PIO beats expansion

    // Reset while dtack_n is low, then strobe still low restarts a cycle.
    bus.as_n         = 1'b0;
    bus.flash_ce     = 1'b1;
    bus.wram_ce      = 1'b0;
    bus.eeprom_ce    = 1'b1;
    bus.pio_ce       = 1'b0;
    bus.expansion_ce = 1'b1;
    e0 = cyc + 1;
    it.kind = 1;
    it.at   = e0 + WRAM_WS + 1;
    exp_q.push_back(it);
    repeat (WRAM_WS + 2) @(negedge clk);
    check("dtack_before_reset", int'(bus.dtack_n), 0);
    #2 reset_n = 1'b0;
    #1;
    exp_flag = 1'b0;
    check("async_reset_dtack_n", int'(bus.dtack_n), 1);
    check("async_reset_berr_n", int'(bus.berr_n), 1);
    check("async_reset_busy", int'(bus.busy), 0);
    check("async_reset_flag", int'(bus.berr_flag), 0);
    @(negedge clk);
    reset_n = 1'b1;
    e0 = cyc + 1;
    it.kind = 1;
    it.at   = e0 + WRAM_WS + 1;
    exp_q.push_back(it);
    repeat (WRAM_WS + 2) @(negedge clk);
    bus.as_n = 1'b1;
    @(negedge clk);
    check("restart_release_dtack_n", int'(bus.dtack_n), 1);
    check("restart_release_busy", int'(bus.busy), 0);

    // Randomized cycles.
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 31));
      k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      a = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 8)) : 0;
      h = int'($urandom_range(0, 3));
      c = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 10)) : 0;
      run_cycle(r[0], r[1], r[2], r[3], r[4], k, a, h, c);
    end

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
